// File: rtl/fetch_sequencer_if.sv
// Program-ROM fetch bus between the fetch sequencer and the program ROM.
// The sequencer (master) raises rom_req with the word address; the ROM
// (slave) answers with rom_valid and the 16-bit program word.
interface fetch_sequencer_if #(
  parameter int PC_W = 12
);
  logic            rom_req;
  logic [PC_W-1:0] rom_addr;
  logic            rom_valid;
  logic [15:0]     rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_valid,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_valid,
    output rom_data
  );
endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer.sv
// Nibbler fetch sequencer: owns the program counter, fetches program words
// over a req/valid ROM bus, latches opcode/operand/jump target and drives the
// decoder phase (0 = fetch, 1 = execute). Run/halt/single-step control lets
// the bench or a debugger stop the core on an instruction boundary.
module fetch_sequencer #(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  fetch_sequencer_if.master   rom,
  input  logic                inc_pc,
  input  logic                load_pc,
  output logic                phase,
  output logic [3:0]          instr,
  output logic [3:0]          operand,
  output logic [PC_W-1:0]     pc,
  output logic                instr_done,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            step_mode;
  logic            step_mode_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] target;
  logic            latch_word;
  logic [PC_W-1:0] pc_inc;

  // Program counter increment wraps naturally modulo 2^PC_W.
  assign pc_inc   = pc + PC_W'(1);
  assign rom.rom_addr = pc;

  // State, step-mode flag and program counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HALT;
      step_mode <= 1'b0;
      pc        <= RESET_PC;
    end else begin
      state     <= state_nxt;
      step_mode <= step_mode_nxt;
      pc        <= pc_nxt;
    end
  end

  // Instruction word fields, captured only when the fetch completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr   <= 4'h0;
      operand <= 4'h0;
      target  <= '0;
    end else if (latch_word) begin
      instr   <= rom.rom_data[15:12];
      operand <= rom.rom_data[3:0];
      target  <= rom.rom_data[PC_W-1:0];
    end
  end

  // Next-state, pc update and per-state outputs.
  always_comb begin
    state_nxt     = state;
    step_mode_nxt = step_mode;
    pc_nxt        = pc;
    latch_word    = 1'b0;
    phase         = 1'b0;
    rom.rom_req   = 1'b0;
    instr_done    = 1'b0;
    halted        = 1'b0;

    case (state)
      S_HALT: begin
        halted = 1'b1;
        // run has priority over step so a held run is never forced into
        // single-step mode.
        if (run) begin
          state_nxt     = S_FETCH;
          step_mode_nxt = 1'b0;
        end else if (step) begin
          state_nxt     = S_FETCH;
          step_mode_nxt = 1'b1;
        end
      end

      S_FETCH: begin
        rom.rom_req = 1'b1;
        // Wait indefinitely for the ROM; pc and latched fields hold meanwhile.
        if (rom.rom_valid) begin
          latch_word = 1'b1;
          // The jump target is not latched yet, so load_pc has no meaning here.
          if (inc_pc) begin
            pc_nxt = pc_inc;
          end
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        phase      = 1'b1;
        instr_done = 1'b1;
        if (load_pc) begin
          pc_nxt = target;
        end else if (inc_pc) begin
          pc_nxt = pc_inc;
        end
        // run is checked here, so dropping it mid-fetch still lets the
        // current instruction finish before halting.
        if (step_mode || !run) begin
          state_nxt     = S_HALT;
          step_mode_nxt = 1'b0;
        end else begin
          state_nxt = S_FETCH;
        end
      end

      default: begin
        state_nxt     = S_HALT;
        step_mode_nxt = 1'b0;
      end
    endcase
  end

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: reset, free-run, jumps, ROM wait
// states, single-step, pc wraparound and asynchronous reset mid-fetch.
module tb_fetch_sequencer;

  localparam int PC_W = 12;

  logic            clk;
  logic            reset;
  logic            run;
  logic            step;
  logic            inc_pc;
  logic            load_pc;
  logic            phase;
  logic [3:0]      instr;
  logic [3:0]      operand;
  logic [PC_W-1:0] pc;
  logic            instr_done;
  logic            halted;

  int vectors;
  int miscompares;

  fetch_sequencer_if #(.PC_W(PC_W)) rom_bus ();

  fetch_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (12'h000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .rom        (rom_bus),
    .inc_pc     (inc_pc),
    .load_pc    (load_pc),
    .phase      (phase),
    .instr      (instr),
    .operand    (operand),
    .pc         (pc),
    .instr_done (instr_done),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    run         = 1'b0;
    step        = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    rom_bus.rom_valid = 1'b0;
    rom_bus.rom_data  = 16'h0000;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, idle while halted
    chk("rst_halted",  32'(halted), 32'h1);
    chk("rst_pc",      32'(pc), 32'h000);
    chk("rst_phase",   32'(phase), 32'h0);
    chk("rst_req",     32'(rom_bus.rom_req), 32'h0);
    chk("rst_instr",   32'(instr), 32'h0);
    chk("rst_done",    32'(instr_done), 32'h0);
    repeat (3) tick();
    chk("idle_halted", 32'(halted), 32'h1);
    chk("idle_req",    32'(rom_bus.rom_req), 32'h0);
    chk("idle_pc",     32'(pc), 32'h000);

    // Free run, 5A03, inc_pc in both phases
    run = 1'b1; rom_bus.rom_valid = 1'b1; rom_bus.rom_data = 16'h5A03; inc_pc = 1'b1;
    tick();
    chk("run_f0_phase", 32'(phase), 32'h0);
    chk("run_f0_req",   32'(rom_bus.rom_req), 32'h1);
    chk("run_f0_addr",  32'(rom_bus.rom_addr), 32'h000);
    chk("run_f0_halt",  32'(halted), 32'h0);
    tick();
    chk("run_e0_phase", 32'(phase), 32'h1);
    chk("run_e0_done",  32'(instr_done), 32'h1);
    chk("run_e0_instr", 32'(instr), 32'h5);
    chk("run_e0_oper",  32'(operand), 32'h3);
    chk("run_e0_pc",    32'(pc), 32'h001);
    chk("run_e0_req",   32'(rom_bus.rom_req), 32'h0);
    tick();
    chk("run_f1_phase", 32'(phase), 32'h0);
    chk("run_f1_done",  32'(instr_done), 32'h0);
    chk("run_f1_pc",    32'(pc), 32'h002);
    tick();
    chk("run_e1_phase", 32'(phase), 32'h1);
    chk("run_e1_pc",    32'(pc), 32'h003);
    tick();
    chk("run_f2_pc",    32'(pc), 32'h004);

    // Jump: load_pc in FETCH ignored, in EXEC loads target
    rom_bus.rom_data = 16'h8123; inc_pc = 1'b0; load_pc = 1'b1;
    tick();
    chk("jmp_e_pc",     32'(pc), 32'h004);
    chk("jmp_e_instr",  32'(instr), 32'h8);
    tick();
    chk("jmp_f_pc",     32'(pc), 32'h123);
    chk("jmp_f_phase",  32'(phase), 32'h0);
    // load_pc only during FETCH: no load
    tick();
    chk("nold_e_pc",    32'(pc), 32'h123);
    load_pc = 1'b0;
    tick();
    chk("nold_f_pc",    32'(pc), 32'h123);

    // ROM wait: three cycles without valid, latch on the 4th
    rom_bus.rom_valid = 1'b0; rom_bus.rom_data = 16'hC0F9;
    for (int i = 0; i < 3; i++) begin
      chk("wait_phase", 32'(phase), 32'h0);
      chk("wait_req",   32'(rom_bus.rom_req), 32'h1);
      chk("wait_addr",  32'(rom_bus.rom_addr), 32'h123);
      chk("wait_instr", 32'(instr), 32'h8);
      tick();
    end
    rom_bus.rom_valid = 1'b1;
    chk("wait4_phase", 32'(phase), 32'h0);
    chk("wait4_req",   32'(rom_bus.rom_req), 32'h1);
    tick();
    chk("wait_e_instr", 32'(instr), 32'hC);
    chk("wait_e_oper",  32'(operand), 32'h9);
    chk("wait_e_phase", 32'(phase), 32'h1);
    run = 1'b0;
    tick();
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_pc",     32'(pc), 32'h123);

    // Single step
    step = 1'b1;
    tick();
    step = 1'b0; rom_bus.rom_data = 16'h2005; inc_pc = 1'b1;
    chk("ss_f_halted", 32'(halted), 32'h0);
    chk("ss_f_req",    32'(rom_bus.rom_req), 32'h1);
    tick();
    chk("ss_e_done",   32'(instr_done), 32'h1);
    chk("ss_e_instr",  32'(instr), 32'h2);
    chk("ss_e_pc",     32'(pc), 32'h124);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("ss_h_halted", 32'(halted), 32'h1);
    chk("ss_h_pc",     32'(pc), 32'h125);
    chk("ss_h_done",   32'(instr_done), 32'h0);
    tick();
    chk("ss_h2_halted", 32'(halted), 32'h1);
    chk("ss_h2_pc",     32'(pc), 32'h125);

    // run and step together: run wins, sequencer keeps going
    run = 1'b1; step = 1'b1; inc_pc = 1'b0;
    tick();
    step = 1'b0;
    tick();
    chk("rs_e_phase", 32'(phase), 32'h1);
    tick();
    chk("rs_f_halted", 32'(halted), 32'h0);
    chk("rs_f_phase",  32'(phase), 32'h0);

    // Wrap: jump to FFF then increment in EXEC
    rom_bus.rom_data = 16'h8FFF;
    tick();
    load_pc = 1'b1;
    tick();
    load_pc = 1'b0;
    chk("wrap_addr", 32'(rom_bus.rom_addr), 32'hFFF);
    tick();
    chk("wrap_e_pc", 32'(pc), 32'hFFF);
    inc_pc = 1'b1;
    tick();
    inc_pc = 1'b0;
    chk("wrap_pc",   32'(pc), 32'h000);

    // Reset mid-FETCH at pc 007
    rom_bus.rom_data = 16'h8007;
    tick();
    load_pc = 1'b1;
    tick();
    load_pc = 1'b0; rom_bus.rom_valid = 1'b0;
    chk("mid_pc",    32'(pc), 32'h007);
    chk("mid_instr", 32'(instr), 32'h8);
    chk("mid_req",   32'(rom_bus.rom_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc",     32'(pc), 32'h000);
    chk("arst_halted", 32'(halted), 32'h1);
    chk("arst_instr",  32'(instr), 32'h0);
    chk("arst_phase",  32'(phase), 32'h0);
    chk("arst_req",    32'(rom_bus.rom_req), 32'h0);
    tick();
    reset = 1'b0; run = 1'b0;
    tick();
    chk("post_halted", 32'(halted), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the phase/instruction side of the Nibbler control interface, the producer end of the decode microROM.
- Owns the 12-bit program counter and requests program words from ROM with a req/valid handshake.
- Latches the opcode nibble into `instr`, the operand nibble and the 12-bit jump target, then toggles `phase` between fetch (0) and execute (1).
- Consumes `incPC`/`loadPC` from the decoder's control word. Adds run/halt/single-step control for the bench and debug.

Parameters:
- PC_W, 12, program counter / ROM address width
- RESET_PC, 12'h000, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level: 1 = free-run, 0 = halt after current instruction
- step  in  1  one-cycle pulse: execute exactly one instruction while halted
- rom_req  out  1  program word request, asserted combinationally in FETCH
- rom_addr  out  PC_W  address of requested word (= pc)
- rom_valid  in  1  ROM word present on rom_data this cycle
- rom_data  in  16  program word: [15:12] opcode, [11:0] jump target, [3:0] operand
- inc_pc  in  1  decoder incPC
- load_pc  in  1  decoder loadPC
- phase  out  1  0 = fetch, 1 = execute; drives decoder phase
- instr  out  4  latched opcode, drives decoder i
- operand  out  4  latched operand nibble, drives oeOperand bus source
- pc  out  PC_W  current program counter
- instr_done  out  1  one-cycle pulse in the EXEC cycle
- halted  out  1  1 while in HALT

Behaviour:
- Reset (async, immediate): state=HALT, pc=RESET_PC, instr=0, operand=0, jump target register=0, phase=0, instr_done=0, halted=1, rom_req=0.
- States: HALT, FETCH, EXEC.
- HALT:
  - phase=0, rom_req=0, halted=1.
  - If run=1: go to FETCH and clear step_mode.
  - Else if step=1: go to FETCH and set step_mode=1.
  - The pc update inputs are ignored.
- FETCH:
  - phase=0, rom_req=1, rom_addr=pc, halted=0.
  - While rom_valid=0: hold state and pc; instr and operand unchanged. No timeout.
  - On rom_valid=1: instr<=rom_data[15:12], operand<=rom_data[3:0], target<=rom_data[11:0].
  - Also on that rom_valid=1 cycle, apply the pc update rule, then go to EXEC.
- EXEC:
  - Exactly one cycle: phase=1, rom_req=0, instr_done=1.
  - Apply the pc update rule.
  - Next state: HALT if step_mode=1 or run=0 (clear step_mode); else FETCH.
- PC update rule, evaluated only in the FETCH-completion cycle and the EXEC cycle:
  - In EXEC, load_pc=1 sets pc<=target. This takes priority over inc_pc.
  - In FETCH, load_pc is ignored.
  - Otherwise inc_pc=1 sets pc<=pc+1, wrapping modulo 2^PC_W (0xFFF -> 0x000).
  - Otherwise pc holds.
- Minimum instruction time: 2 cycles (FETCH with immediate rom_valid, then EXEC).
- run falling during FETCH: the current instruction completes (the fetch finishes and EXEC executes), then the sequencer goes to HALT.
- step while not in HALT: ignored.
- step and run both high in HALT: run wins (free-run).
- reset asserted mid-FETCH or mid-EXEC: the instruction is aborted, the pc update is discarded, and all state returns to reset values.
- rom_data is sampled only in the FETCH cycle with rom_valid=1; it is don't-care otherwise.

Test Plan:
- Reset release, run=0 -> halted=1, pc=0x000, phase=0, rom_req=0 indefinitely; step=0.
- run=1, rom_valid always 1, rom_data=16'h5A03, inc_pc=1 in both phases -> phase 0,1,0,1…
  - instr=4'h5 and operand=4'h3 after first fetch.
  - pc steps 0,1,2,… by 2 per instruction (inc_pc=1 in both the fetch-completion and EXEC cycles).
  - instr_done every 2nd cycle.
- Jump: the fetched word is 16'h8123 and load_pc=1 in EXEC -> pc=0x123 next cycle.
  - Same word with load_pc=1 during FETCH only -> no load.
- ROM wait: rom_valid low for 3 cycles -> rom_req held, rom_addr stable, phase=0 for 4 cycles total.
  - Latch occurs on the 4th cycle.
- Single step from HALT: one step pulse -> exactly one FETCH+EXEC, one instr_done pulse, back to halted=1.
  - A second step pulse during EXEC is ignored.
- pc=0xFFF, inc_pc=1 in EXEC -> pc=0x000.
  - Assert reset mid-FETCH at pc=0x007 -> immediately pc=0x000, halted=1, instr=0.
